fp_div_iter: RTL



---
 rtl/fp_div_iter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fp_div_iter.sv
// Iterative FP32 divider, restoring radix-2, one quotient bit per clock, RNE rounding.
// Fixed 28-cycle latency from accept to done; normal/zero operands only, flush-to-zero underflow.
module fp_div_iter #(
  parameter int QBITS = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] X,
  input  logic [31:0] Y,
  output logic        busy,
  output logic        done,
  output logic [31:0] R
);

  localparam int CW = $clog2(QBITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_ROUND
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       xop_q, xop_d;
  logic [31:0]       yop_q, yop_d;
  logic              sign_q, sign_d;
  logic [9:0]        exp_q, exp_d;
  logic [25:0]       rem_q, rem_d;
  logic [QBITS-1:0]  quo_q, quo_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [31:0]       res_q, res_d;
  logic              done_q, done_d;

  logic [23:0]       mant_y;
  logic              rem_ge;
  logic [25:0]       rem_sub;
  logic [25:0]       rem_step;

  logic              q_hi;
  logic [23:0]       man_n;
  logic              grd, stk, inc;
  logic [9:0]        exp_n;
  logic [24:0]       man_inc;
  logic [23:0]       man_r;
  logic [9:0]        exp_r;
  logic [31:0]       packed_res;

  assign mant_y   = {1'b1, yop_q[22:0]};
  assign rem_ge   = rem_q >= {2'b00, mant_y};
  assign rem_sub  = rem_q - {2'b00, mant_y};
  // rem stays below 2*mY, so the shifted value never loses its top bit
  assign rem_step = rem_ge ? {rem_sub[24:0], 1'b0} : {rem_q[24:0], 1'b0};

  always_comb begin
    q_hi  = quo_q[25];
    man_n = q_hi ? quo_q[25:2] : quo_q[24:1];
    grd   = q_hi ? quo_q[1] : quo_q[0];
    stk   = (q_hi & quo_q[0]) | (|rem_q);
    exp_n = q_hi ? exp_q : exp_q - 10'd1;
    inc   = grd & (stk | man_n[0]);
    man_inc = {1'b0, man_n} + {24'd0, inc};
    if (man_inc[24]) begin
      man_r = 24'h800000;
      exp_r = exp_n + 10'd1;
    end else begin
      man_r = man_inc[23:0];
      exp_r = exp_n;
    end

    if (yop_q[30:23] == 8'd0) begin
      packed_res = {sign_q, 8'hFF, 23'd0};
    end else if (xop_q[30:23] == 8'd0) begin
      packed_res = {sign_q, 31'd0};
    end else if ($signed(exp_r) >= 10'sd255) begin
      packed_res = {sign_q, 8'hFF, 23'd0};
    end else if ($signed(exp_r) <= 10'sd0) begin
      packed_res = {sign_q, 31'd0};
    end else begin
      packed_res = {sign_q, exp_r[7:0], man_r[22:0]};
    end
  end

  always_comb begin
    state_d = state_q;
    xop_d   = xop_q;
    yop_d   = yop_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          xop_d   = X;
          yop_d   = Y;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        sign_d  = xop_q[31] ^ yop_q[31];
        exp_d   = {2'b00, xop_q[30:23]} - {2'b00, yop_q[30:23]} + 10'd127;
        rem_d   = {2'b00, 1'b1, xop_q[22:0]};
        quo_d   = '0;
        cnt_d   = CW'(QBITS - 1);
        state_d = S_ITER;
      end
      S_ITER: begin
        quo_d = {quo_q[QBITS-2:0], rem_ge};
        rem_d = rem_step;
        if (cnt_q == '0) begin
          state_d = S_ROUND;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_ROUND: begin
        res_d   = packed_res;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      xop_q   <= '0;
      yop_q   <= '0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xop_q   <= xop_d;
      yop_q   <= yop_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == S_ITER) || (state_q == S_ROUND);
  assign done = done_q;
  assign R    = res_q;

endmodule
